dff_asr_ctl_gen: RTL and testbench

Sequencer that drives the asynchronous active-low set/clear pins (RSTB/SETB) of a bank of negative-edge set/reset flip-flops from a synchronous request interface. It guarantees glitch-free, mutually exclusive strobes with a programmable minimum pulse width. It also enforces a recovery window, during which the bank's clock enable is held off, before the bank is clocked again. It sits between the control logic and the flop bank, on the driving end of the RSTB/SETB/CLK-gating pins.

---
 rtl/dff_asr_ctl_gen_if.sv | 33 +++
 rtl/dff_asr_ctl_gen.sv | 126 ++++++++++++
 tb/tb_dff_asr_ctl_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dff_asr_ctl_gen_if.sv
// Request/strobe bundle between control logic and the set/clear sequencer.
// ASR_CTL_ERR_EN adds the sticky protocol-error line.
interface dff_asr_ctl_gen_if;
    logic req_valid;
    logic req_set;
    logic req_ready;
    logic done;
    logic busy;
    logic q_rstb;
    logic q_setb;
    logic clk_en;
`ifdef ASR_CTL_ERR_EN
    logic err;

    modport master (
        output req_valid, req_set,
        input  req_ready, done, busy, q_rstb, q_setb, clk_en, err
    );
    modport slave (
        input  req_valid, req_set,
        output req_ready, done, busy, q_rstb, q_setb, clk_en, err
    );
`else
    modport master (
        output req_valid, req_set,
        input  req_ready, done, busy, q_rstb, q_setb, clk_en
    );
    modport slave (
        input  req_valid, req_set,
        output req_ready, done, busy, q_rstb, q_setb, clk_en
    );
`endif
endinterface

// File: rtl/dff_asr_ctl_gen.sv
// Sequencer for the async RSTB/SETB pins of a flop bank: strobe, recovery, done.
// Define ASR_CTL_ERR_EN to add the sticky request-stability checker (bus.err).
module dff_asr_ctl_gen #(
    parameter int PW_CYC  = 2,
    parameter int REC_CYC = 2,
    parameter int CNT_W   = 4
) (
    input  logic              clk_i,
    input  logic              rstb_i,
    dff_asr_ctl_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PW_CYC - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(REC_CYC - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             kind_q;
    logic             q_rstb_q;
    logic             q_setb_q;
    logic             clk_en_q;
    logic             done_q;
    logic             accept;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.q_rstb    = q_rstb_q;
    assign bus.q_setb    = q_setb_q;
    assign bus.clk_en    = clk_en_q;

    assign accept = bus.req_valid & bus.req_ready;
    assign cnt_d  = cnt_q + 1'b1;

    // Strobe polarity is taken from req_set only at acceptance; afterwards kind_q
    // alone decides, so late changes on req_set cannot glitch the other strobe.
    always_ff @(posedge clk_i) begin
        if (!rstb_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            kind_q   <= 1'b0;
            q_rstb_q <= 1'b1;
            q_setb_q <= 1'b1;
            clk_en_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    clk_en_q <= 1'b1;
                    if (accept) begin
                        state_q  <= ASSERT;
                        cnt_q    <= '0;
                        kind_q   <= bus.req_set;
                        q_rstb_q <= bus.req_set;
                        q_setb_q <= ~bus.req_set;
                        clk_en_q <= 1'b0;
                    end
                end
                ASSERT: begin
                    q_rstb_q <= kind_q;
                    q_setb_q <= ~kind_q;
                    if (cnt_q == PW_LAST) begin
                        state_q  <= RECOVER;
                        cnt_q    <= '0;
                        q_rstb_q <= 1'b1;
                        q_setb_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RECOVER: begin
                    if (cnt_q == REC_LAST) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        done_q   <= 1'b1;
                        clk_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    q_rstb_q <= 1'b1;
                    q_setb_q <= 1'b1;
                    clk_en_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef ASR_CTL_ERR_EN
    logic vld_q;
    logic set_q;
    logic rdy_q;
    logic err_q;
    logic err_d;

    // A request left waiting (valid while not ready) must stay valid and stable.
    assign err_d   = err_q | (vld_q & ~rdy_q & (~bus.req_valid | (bus.req_set != set_q)));
    assign bus.err = err_q;

    always_ff @(posedge clk_i) begin
        if (!rstb_i) begin
            vld_q <= 1'b0;
            set_q <= 1'b0;
            rdy_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            vld_q <= bus.req_valid;
            set_q <= bus.req_set;
            rdy_q <= bus.req_ready;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_dff_asr_ctl_gen.sv
// Bench for dff_asr_ctl_gen: three parameter sets, timing-formula model plus strobe-kind scoreboard.
module tb_dff_asr_ctl_gen;

    localparam int PW_T  [3] = '{2, 3, 1};
    localparam int REC_T [3] = '{2, 2, 1};

    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic rstb [3];
    logic vld  [3];
    logic set  [3];

    dff_asr_ctl_gen_if b0 ();
    dff_asr_ctl_gen_if b1 ();
    dff_asr_ctl_gen_if b2 ();

    assign b0.req_valid = vld[0];
    assign b0.req_set   = set[0];
    assign b1.req_valid = vld[1];
    assign b1.req_set   = set[1];
    assign b2.req_valid = vld[2];
    assign b2.req_set   = set[2];

    dff_asr_ctl_gen #(.PW_CYC(2), .REC_CYC(2), .CNT_W(4)) u0 (.clk_i(gclk), .rstb_i(rstb[0]), .bus(b0));
    dff_asr_ctl_gen #(.PW_CYC(3), .REC_CYC(2), .CNT_W(4)) u1 (.clk_i(gclk), .rstb_i(rstb[1]), .bus(b1));
    dff_asr_ctl_gen #(.PW_CYC(1), .REC_CYC(1), .CNT_W(4)) u2 (.clk_i(gclk), .rstb_i(rstb[2]), .bus(b2));

    // {ready, done, busy, q_rstb, q_setb, clk_en, err}
    logic [6:0] obs [3];
`ifdef ASR_CTL_ERR_EN
    assign obs[0] = {b0.req_ready, b0.done, b0.busy, b0.q_rstb, b0.q_setb, b0.clk_en, b0.err};
    assign obs[1] = {b1.req_ready, b1.done, b1.busy, b1.q_rstb, b1.q_setb, b1.clk_en, b1.err};
    assign obs[2] = {b2.req_ready, b2.done, b2.busy, b2.q_rstb, b2.q_setb, b2.clk_en, b2.err};
`else
    assign obs[0] = {b0.req_ready, b0.done, b0.busy, b0.q_rstb, b0.q_setb, b0.clk_en, 1'b0};
    assign obs[1] = {b1.req_ready, b1.done, b1.busy, b1.q_rstb, b1.q_setb, b1.clk_en, 1'b0};
    assign obs[2] = {b2.req_ready, b2.done, b2.busy, b2.q_rstb, b2.q_setb, b2.clk_en, 1'b0};
`endif

    int checks = 0;
    int errors = 0;

    // model: e_m = edges since acceptance (-1 when idle), kind_m = latched kind
    int   e_m    [3];
    logic kind_m [3];
    logic err_m  [3];
    logic pv [3], ps [3], pr [3];
    logic plow [3];
    logic sb [3][$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_of(input int d);
        int pw  = PW_T[d];
        int rec = REC_T[d];
        int e   = e_m[d];
        logic ef;
`ifdef ASR_CTL_ERR_EN
        ef = err_m[d];
`else
        ef = 1'b0;
`endif
        if (e < 0)             return {6'b100111, ef};
        else if (e < pw)       return {3'b001, kind_m[d], ~kind_m[d], 1'b0, ef};
        else if (e < pw + rec) return {6'b001110, ef};
        else                   return {6'b110111, ef};
    endfunction

    task automatic step();
        logic rdy;
        logic low;
        logic k;
        @(posedge gclk);
        for (int d = 0; d < 3; d++) begin
            if (!rstb[d]) begin
                e_m[d] = -1; err_m[d] = 1'b0;
                pv[d] = 1'b0; ps[d] = 1'b0; pr[d] = 1'b0;
                sb[d].delete();
            end else begin
                rdy = (e_m[d] < 0) || (e_m[d] >= PW_T[d] + REC_T[d]);
                if (pv[d] && !pr[d] && (!vld[d] || (set[d] != ps[d]))) err_m[d] = 1'b1;
                if (vld[d] && rdy) begin
                    e_m[d] = 0;
                    kind_m[d] = set[d];
                    sb[d].push_back(set[d]);
                end else if (e_m[d] >= 0) begin
                    e_m[d]++;
                    if (e_m[d] > PW_T[d] + REC_T[d]) e_m[d] = -1;
                end
                pv[d] = vld[d]; ps[d] = set[d]; pr[d] = rdy;
            end
        end
        @(negedge gclk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("out%0d", d), 32'(obs[d]), 32'(exp_of(d)));
            chk($sformatf("excl%0d", d), 32'(obs[d][3] | obs[d][2]), 32'd1);
            low = !obs[d][3] || !obs[d][2];
            if (low && !plow[d]) begin
                if (sb[d].size() == 0) begin
                    chk($sformatf("sb_under%0d", d), 32'(sb[d].size()), 32'd1);
                end else begin
                    k = sb[d].pop_front();
                    chk($sformatf("sb_kind%0d", d), 32'(!obs[d][2]), 32'(k));
                end
            end
            plow[d] = low;
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rstb[d] = 1'b0; vld[d] = 1'b0; set[d] = 1'b0;
            e_m[d] = -1; kind_m[d] = 1'b0; err_m[d] = 1'b0;
            pv[d] = 1'b0; ps[d] = 1'b0; pr[d] = 1'b0; plow[d] = 1'b0;
        end
        repeat (2) step();
        for (int d = 0; d < 3; d++) rstb[d] = 1'b1;
        repeat (2) step();

        // single clear pulse on PW=2/REC=2
        vld[0] = 1'b1; set[0] = 1'b0;
        step();
        vld[0] = 1'b0;
        repeat (6) step();

        // set then clear back-to-back with valid held
        vld[0] = 1'b1; set[0] = 1'b1;
        step();
        set[0] = 1'b0;
        repeat (5) step();
        vld[0] = 1'b0;
        repeat (7) step();

        // req_set toggled mid-set with valid held
        rstb[0] = 1'b0;
        step();
        rstb[0] = 1'b1;
        vld[0] = 1'b1; set[0] = 1'b1;
        step();
        step();
        set[0] = 1'b0;
        step();
        vld[0] = 1'b0;
        repeat (7) step();

        // reset at edge 1 of a PW=3 clear
        vld[1] = 1'b1; set[1] = 1'b0;
        step();
        vld[1] = 1'b0; rstb[1] = 1'b0;
        step();
        rstb[1] = 1'b1;
        repeat (8) step();

        // minimum widths, set then clear
        vld[2] = 1'b1; set[2] = 1'b1;
        step();
        vld[2] = 1'b0;
        repeat (4) step();
        vld[2] = 1'b1; set[2] = 1'b0;
        step();
        vld[2] = 1'b0;
        repeat (4) step();

        // random traffic on all three
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < 3; d++) begin
                vld[d]  = ($urandom_range(0, 2) != 0);
                set[d]  = $urandom_range(0, 1) != 0;
                rstb[d] = ($urandom_range(0, 60) != 0);
            end
            step();
        end
        for (int d = 0; d < 3; d++) begin
            vld[d] = 1'b0; rstb[d] = 1'b1;
        end
        repeat (10) step();
        for (int d = 0; d < 3; d++) chk($sformatf("sb_left%0d", d), 32'(sb[d].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
